// File: rtl/toy_pack.sv
// Shared RV32I decode types: opcode constants, op classes, immediate formats
// and the immediate-assembly helper.
package toy_pack;

    localparam int INST_FIELD_OPCODE   = 0;
    localparam int INST_FIELD_OPCODE_W = 7;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_ILLEGAL = 4'd11
    } dec_class_e;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/toy_scoreboard.sv
// In-flight register writer tracking: one busy bit per architectural register,
// x0 never busy. A set beats any clear aimed at the same register.
module toy_scoreboard
    import toy_pack::*;
#(
    parameter int REG_NUM = 32,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic             fclr_en_i,
    input  logic [IDX_W-1:0] fclr_idx_i,
    input  logic [IDX_W-1:0] q1_idx_i,
    input  logic [IDX_W-1:0] q2_idx_i,
    input  logic [IDX_W-1:0] q3_idx_i,
    output logic             q1_busy_o,
    output logic             q2_busy_o,
    output logic             q3_busy_o
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    // Next busy vector: set wins over writeback and flush clears.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < REG_NUM; i++) begin
            busy_d[i] = (set_en_i && (set_idx_i == IDX_W'(i))) ? 1'b1 :
                        ((clr_en_i && (clr_idx_i == IDX_W'(i))) ||
                         (fclr_en_i && (fclr_idx_i == IDX_W'(i)))) ? 1'b0 : busy_q[i];
        end
    end

    // Busy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy_o = busy_q[q1_idx_i];
    assign q2_busy_o = busy_q[q2_idx_i];
    assign q3_busy_o = busy_q[q3_idx_i];

endmodule

// File: rtl/toy_decode.sv
// RV32I decode stage: cracks fetched instructions into a single registered
// output slot, stalling fetch on RAW/WAW hazards and dropping work on redirect.
module toy_decode
    import toy_pack::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instruction_vld,
    output logic                  instruction_rdy,
    input  logic [INST_WIDTH-1:0] instruction_pld,
    input  logic [ADDR_WIDTH-1:0] instruction_pc,
    input  logic                  flush_en,
    output logic                  dec_vld,
    input  logic                  dec_rdy,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [3:0]            dec_class,
    output logic [4:0]            dec_rd,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [31:0]           dec_imm,
    output logic                  dec_rd_wen,
    input  logic                  wb_vld,
    input  logic [4:0]            wb_rd
);

    logic [6:0]       opcode_s;
    logic [4:0]       rd_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    dec_class_e       cls_s;
    imm_fmt_e         fmt_s;
    logic             rs1_use_s;
    logic             rs2_use_s;
    logic             wen_raw_s;
    logic             rd_wen_s;
    logic [31:0]      imm_s;
    logic             rs1_busy_s;
    logic             rs2_busy_s;
    logic             rd_busy_s;
    logic             hazard_s;
    logic             accept_s;
    logic             drain_s;
    logic             fclr_en_s;

    logic                  dec_vld_q,    dec_vld_d;
    logic [ADDR_WIDTH-1:0] dec_pc_q,     dec_pc_d;
    logic [INST_WIDTH-1:0] dec_inst_q,   dec_inst_d;
    dec_class_e            dec_class_q,  dec_class_d;
    logic [4:0]            dec_rd_q,     dec_rd_d;
    logic [4:0]            dec_rs1_q,    dec_rs1_d;
    logic [4:0]            dec_rs2_q,    dec_rs2_d;
    logic [31:0]           dec_imm_q,    dec_imm_d;
    logic                  dec_rd_wen_q, dec_rd_wen_d;

    assign opcode_s = instruction_pld[INST_FIELD_OPCODE +: INST_FIELD_OPCODE_W];
    assign rd_s     = instruction_pld[11:7];
    assign rs1_s    = instruction_pld[19:15];
    assign rs2_s    = instruction_pld[24:20];

    // Opcode crack; every legal opcode ends in 2'b11, so compressed or unknown encodings fall to ILLEGAL.
    always_comb begin
        cls_s     = CLS_ILLEGAL;
        fmt_s     = FMT_NONE;
        rs1_use_s = 1'b0;
        rs2_use_s = 1'b0;
        wen_raw_s = 1'b0;
        case (opcode_s)
            OPC_OP:       begin cls_s = CLS_ALU_R;  fmt_s = FMT_NONE; rs1_use_s = 1'b1; rs2_use_s = 1'b1; wen_raw_s = 1'b1; end
            OPC_OP_IMM:   begin cls_s = CLS_ALU_I;  fmt_s = FMT_I;    rs1_use_s = 1'b1; wen_raw_s = 1'b1; end
            OPC_LOAD:     begin cls_s = CLS_LOAD;   fmt_s = FMT_I;    rs1_use_s = 1'b1; wen_raw_s = 1'b1; end
            OPC_STORE:    begin cls_s = CLS_STORE;  fmt_s = FMT_S;    rs1_use_s = 1'b1; rs2_use_s = 1'b1; end
            OPC_BRANCH:   begin cls_s = CLS_BRANCH; fmt_s = FMT_B;    rs1_use_s = 1'b1; rs2_use_s = 1'b1; end
            OPC_JAL:      begin cls_s = CLS_JAL;    fmt_s = FMT_J;    wen_raw_s = 1'b1; end
            OPC_JALR:     begin cls_s = CLS_JALR;   fmt_s = FMT_I;    rs1_use_s = 1'b1; wen_raw_s = 1'b1; end
            OPC_LUI:      begin cls_s = CLS_LUI;    fmt_s = FMT_U;    wen_raw_s = 1'b1; end
            OPC_AUIPC:    begin cls_s = CLS_AUIPC;  fmt_s = FMT_U;    wen_raw_s = 1'b1; end
            OPC_SYSTEM:   begin cls_s = CLS_SYSTEM; fmt_s = FMT_I;    rs1_use_s = 1'b1; wen_raw_s = 1'b1; end
            OPC_MISC_MEM: begin cls_s = CLS_FENCE;  fmt_s = FMT_NONE; end
            default:      begin cls_s = CLS_ILLEGAL; fmt_s = FMT_NONE; end
        endcase
    end

    assign imm_s    = imm_gen(instruction_pld[31:0], fmt_s);
    assign rd_wen_s = wen_raw_s & (rd_s != 5'd0);

    assign hazard_s        = (rs1_use_s & rs1_busy_s) | (rs2_use_s & rs2_busy_s) | (rd_wen_s & rd_busy_s);
    assign instruction_rdy = ~flush_en & ~hazard_s & (~dec_vld_q | dec_rdy);
    assign accept_s        = instruction_vld & instruction_rdy;
    assign drain_s         = dec_vld_q & dec_rdy;
    // An entry drained in the flush cycle has issued, so only a stuck entry releases its rd.
    assign fclr_en_s       = flush_en & dec_vld_q & ~dec_rdy & dec_rd_wen_q;

    toy_scoreboard #(
        .REG_NUM (REG_NUM),
        .IDX_W   (5)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (accept_s & rd_wen_s),
        .set_idx_i  (rd_s),
        .clr_en_i   (wb_vld),
        .clr_idx_i  (wb_rd),
        .fclr_en_i  (fclr_en_s),
        .fclr_idx_i (dec_rd_q),
        .q1_idx_i   (rs1_s),
        .q2_idx_i   (rs2_s),
        .q3_idx_i   (rd_s),
        .q1_busy_o  (rs1_busy_s),
        .q2_busy_o  (rs2_busy_s),
        .q3_busy_o  (rd_busy_s)
    );

    // Output slot next state: flush empties, accept loads, drain empties, else hold.
    always_comb begin
        dec_vld_d    = dec_vld_q;
        dec_pc_d     = dec_pc_q;
        dec_inst_d   = dec_inst_q;
        dec_class_d  = dec_class_q;
        dec_rd_d     = dec_rd_q;
        dec_rs1_d    = dec_rs1_q;
        dec_rs2_d    = dec_rs2_q;
        dec_imm_d    = dec_imm_q;
        dec_rd_wen_d = dec_rd_wen_q;
        if (flush_en) begin
            dec_vld_d = 1'b0;
        end else if (accept_s) begin
            dec_vld_d    = 1'b1;
            dec_pc_d     = instruction_pc;
            dec_inst_d   = instruction_pld;
            dec_class_d  = cls_s;
            dec_rd_d     = rd_s;
            dec_rs1_d    = rs1_s;
            dec_rs2_d    = rs2_s;
            dec_imm_d    = imm_s;
            dec_rd_wen_d = rd_wen_s;
        end else if (drain_s) begin
            dec_vld_d = 1'b0;
        end else begin
            dec_vld_d = dec_vld_q;
        end
    end

    // Output slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_vld_q    <= 1'b0;
            dec_pc_q     <= '0;
            dec_inst_q   <= '0;
            dec_class_q  <= CLS_ALU_R;
            dec_rd_q     <= 5'd0;
            dec_rs1_q    <= 5'd0;
            dec_rs2_q    <= 5'd0;
            dec_imm_q    <= 32'h0000_0000;
            dec_rd_wen_q <= 1'b0;
        end else begin
            dec_vld_q    <= dec_vld_d;
            dec_pc_q     <= dec_pc_d;
            dec_inst_q   <= dec_inst_d;
            dec_class_q  <= dec_class_d;
            dec_rd_q     <= dec_rd_d;
            dec_rs1_q    <= dec_rs1_d;
            dec_rs2_q    <= dec_rs2_d;
            dec_imm_q    <= dec_imm_d;
            dec_rd_wen_q <= dec_rd_wen_d;
        end
    end

    assign dec_vld    = dec_vld_q;
    assign dec_pc     = dec_pc_q;
    assign dec_inst   = dec_inst_q;
    assign dec_class  = dec_class_q;
    assign dec_rd     = dec_rd_q;
    assign dec_rs1    = dec_rs1_q;
    assign dec_rs2    = dec_rs2_q;
    assign dec_imm    = dec_imm_q;
    assign dec_rd_wen = dec_rd_wen_q;

endmodule

// File: tb/tb_toy_decode.sv
// Directed bench for toy_decode: reset, hazards, backpressure, flush,
// illegal/x0 handling and immediate formats.
module tb_toy_decode;

    logic        clk;
    logic        rst_n;
    logic        instruction_vld;
    logic        instruction_rdy;
    logic [31:0] instruction_pld;
    logic [31:0] instruction_pc;
    logic        flush_en;
    logic        dec_vld;
    logic        dec_rdy;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [3:0]  dec_class;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_rd_wen;
    logic        wb_vld;
    logic [4:0]  wb_rd;

    int checks;
    int errors;

    toy_decode dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instruction_vld (instruction_vld),
        .instruction_rdy (instruction_rdy),
        .instruction_pld (instruction_pld),
        .instruction_pc  (instruction_pc),
        .flush_en        (flush_en),
        .dec_vld         (dec_vld),
        .dec_rdy         (dec_rdy),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .dec_class       (dec_class),
        .dec_rd          (dec_rd),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_imm         (dec_imm),
        .dec_rd_wen      (dec_rd_wen),
        .wb_vld          (wb_vld),
        .wb_rd           (wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instruction_vld = 1'b0; instruction_pld = 32'h0; instruction_pc = 32'h0;
        flush_en = 1'b0; dec_rdy = 1'b1; wb_vld = 1'b0; wb_rd = 5'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        checks++; if (dec_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", dec_vld); end
        checks++; if (dec_pc !== 32'h0 || dec_inst !== 32'h0 || dec_imm !== 32'h0) begin errors++; $display("FAIL reset_payload got pc %h inst %h imm %h exp 0", dec_pc, dec_inst, dec_imm); end
        checks++; if (dec_rd !== 5'd0 || dec_rd_wen !== 1'b0 || dec_class !== 4'd0) begin errors++; $display("FAIL reset_fields got rd %0d wen %0b cls %0d exp 0", dec_rd, dec_rd_wen, dec_class); end
        checks++; if (instruction_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", instruction_rdy); end
        checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", dut.u_sb.busy_q); end
    endtask

    task automatic test_alu_i();
        instruction_pld = 32'h00500093; instruction_pc = 32'h80000000; instruction_vld = 1'b1; dec_rdy = 1'b1;
        tick();
        instruction_vld = 1'b0;
        checks++; if (dec_vld !== 1'b1) begin errors++; $display("FAIL addi_vld got %0b exp 1", dec_vld); end
        checks++; if (dec_class !== 4'd1) begin errors++; $display("FAIL addi_class got %0d exp 1", dec_class); end
        checks++; if (dec_rd !== 5'd1 || dec_rd_wen !== 1'b1) begin errors++; $display("FAIL addi_rd got %0d/%0b exp 1/1", dec_rd, dec_rd_wen); end
        checks++; if (dec_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %h exp 5", dec_imm); end
        checks++; if (dec_pc !== 32'h80000000 || dec_inst !== 32'h00500093) begin errors++; $display("FAIL addi_pc got %h %h exp 80000000 00500093", dec_pc, dec_inst); end
        checks++; if (dut.u_sb.busy_q[1] !== 1'b1) begin errors++; $display("FAIL addi_busy1 got %0b exp 1", dut.u_sb.busy_q[1]); end
    endtask

    task automatic test_raw_hazard();
        instruction_pld = 32'h00108133; instruction_pc = 32'h80000004; instruction_vld = 1'b1;
        #1;
        checks++; if (instruction_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall got %0b exp 0", instruction_rdy); end
        tick();
        wb_vld = 1'b1; wb_rd = 5'd1;
        #1;
        checks++; if (instruction_rdy !== 1'b0) begin errors++; $display("FAIL raw_nobypass got %0b exp 0", instruction_rdy); end
        tick();
        wb_vld = 1'b0;
        #1;
        checks++; if (instruction_rdy !== 1'b1) begin errors++; $display("FAIL raw_release got %0b exp 1", instruction_rdy); end
        tick();
        instruction_vld = 1'b0;
        checks++; if (dec_vld !== 1'b1 || dec_class !== 4'd0) begin errors++; $display("FAIL add_class got vld %0b cls %0d exp 1/0", dec_vld, dec_class); end
        checks++; if (dec_rs1 !== 5'd1 || dec_rs2 !== 5'd1 || dec_rd !== 5'd2) begin errors++; $display("FAIL add_regs got %0d %0d %0d exp 1 1 2", dec_rs1, dec_rs2, dec_rd); end
        wb_vld = 1'b1; wb_rd = 5'd2;
        tick();
        wb_vld = 1'b0;
        checks++; if (dec_vld !== 1'b0 || dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL add_drain got vld %0b busy %h exp 0/0", dec_vld, dut.u_sb.busy_q); end
    endtask

    task automatic test_backpressure();
        dec_rdy = 1'b0;
        instruction_pld = 32'h00802183; instruction_pc = 32'h80000008; instruction_vld = 1'b1;
        tick();
        instruction_pld = 32'h00100213; instruction_pc = 32'h8000000C;
        for (int k = 0; k < 3; k++) begin
            checks++; if (dec_vld !== 1'b1 || dec_class !== 4'd2 || dec_rd !== 5'd3 || dec_imm !== 32'd8 || dec_pc !== 32'h80000008)
                begin errors++; $display("FAIL bp_hold%0d got vld %0b cls %0d rd %0d imm %h pc %h exp 1 2 3 8 80000008", k, dec_vld, dec_class, dec_rd, dec_imm, dec_pc); end
            checks++; if (instruction_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got %0b exp 0", k, instruction_rdy); end
            tick();
        end
        dec_rdy = 1'b1;
        #1;
        checks++; if (instruction_rdy !== 1'b1) begin errors++; $display("FAIL bp_drain_rdy got %0b exp 1", instruction_rdy); end
        tick();
        instruction_vld = 1'b0;
        checks++; if (dec_vld !== 1'b1 || dec_pc !== 32'h8000000C || dec_class !== 4'd1 || dec_rd !== 5'd4 || dec_imm !== 32'd1)
            begin errors++; $display("FAIL bp_nobubble got vld %0b pc %h cls %0d rd %0d imm %h exp 1 8000000c 1 4 1", dec_vld, dec_pc, dec_class, dec_rd, dec_imm); end
        wb_vld = 1'b1; wb_rd = 5'd3;
        tick();
        wb_rd = 5'd4;
        tick();
        wb_vld = 1'b0;
        checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL bp_busy_clean got %h exp 0", dut.u_sb.busy_q); end
    endtask

    task automatic test_flush();
        dec_rdy = 1'b0;
        instruction_pld = 32'h00802183; instruction_pc = 32'h80000010; instruction_vld = 1'b1;
        tick();
        instruction_vld = 1'b0;
        checks++; if (dut.u_sb.busy_q[3] !== 1'b1) begin errors++; $display("FAIL fl_busy_set got %0b exp 1", dut.u_sb.busy_q[3]); end
        flush_en = 1'b1;
        #1;
        checks++; if (instruction_rdy !== 1'b0) begin errors++; $display("FAIL fl_rdy got %0b exp 0", instruction_rdy); end
        tick();
        flush_en = 1'b0;
        checks++; if (dec_vld !== 1'b0) begin errors++; $display("FAIL fl_vld got %0b exp 0", dec_vld); end
        checks++; if (dut.u_sb.busy_q[3] !== 1'b0) begin errors++; $display("FAIL fl_busy_clr got %0b exp 0", dut.u_sb.busy_q[3]); end
        instruction_pld = 32'h00802183; instruction_pc = 32'h80000014; instruction_vld = 1'b1;
        tick();
        instruction_pld = 32'h00100293; instruction_pc = 32'h80000018;
        dec_rdy = 1'b1; flush_en = 1'b1;
        tick();
        flush_en = 1'b0; instruction_vld = 1'b0;
        checks++; if (dec_vld !== 1'b0) begin errors++; $display("FAIL fl2_vld got %0b exp 0", dec_vld); end
        checks++; if (dut.u_sb.busy_q[3] !== 1'b1) begin errors++; $display("FAIL fl2_busy_keep got %0b exp 1", dut.u_sb.busy_q[3]); end
        checks++; if (dut.u_sb.busy_q[5] !== 1'b0) begin errors++; $display("FAIL fl2_noaccept got %0b exp 0", dut.u_sb.busy_q[5]); end
        wb_vld = 1'b1; wb_rd = 5'd3;
        tick();
        wb_vld = 1'b0;
    endtask

    task automatic test_illegal_x0();
        dec_rdy = 1'b1;
        instruction_pld = 32'h00000000; instruction_pc = 32'h80000020; instruction_vld = 1'b1;
        tick();
        checks++; if (dec_vld !== 1'b1 || dec_class !== 4'd11 || dec_rd_wen !== 1'b0)
            begin errors++; $display("FAIL illegal got vld %0b cls %0d wen %0b exp 1 11 0", dec_vld, dec_class, dec_rd_wen); end
        checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL illegal_busy got %h exp 0", dut.u_sb.busy_q); end
        instruction_pld = 32'h00000013; instruction_pc = 32'h80000024;
        tick();
        checks++; if (dec_class !== 4'd1 || dec_rd_wen !== 1'b0) begin errors++; $display("FAIL nop got cls %0d wen %0b exp 1 0", dec_class, dec_rd_wen); end
        checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL nop_busy got %h exp 0", dut.u_sb.busy_q); end
        instruction_pld = 32'h00000333; instruction_pc = 32'h80000028;
        #1;
        checks++; if (instruction_rdy !== 1'b1) begin errors++; $display("FAIL x0_nostall got %0b exp 1", instruction_rdy); end
        tick();
        instruction_vld = 1'b0;
        checks++; if (dec_class !== 4'd0 || dec_rd !== 5'd6 || dec_rd_wen !== 1'b1) begin errors++; $display("FAIL add_x0 got cls %0d rd %0d wen %0b exp 0 6 1", dec_class, dec_rd, dec_rd_wen); end
        wb_vld = 1'b1; wb_rd = 5'd6;
        tick();
        wb_vld = 1'b0;
    endtask

    task automatic test_imm_formats();
        dec_rdy = 1'b1;
        instruction_pld = 32'hFE000EE3; instruction_pc = 32'h80000030; instruction_vld = 1'b1;
        tick();
        checks++; if (dec_class !== 4'd4 || dec_imm !== 32'hFFFFFFFC || dec_rd_wen !== 1'b0)
            begin errors++; $display("FAIL beq got cls %0d imm %h wen %0b exp 4 fffffffc 0", dec_class, dec_imm, dec_rd_wen); end
        instruction_pld = 32'h001000EF; instruction_pc = 32'h80000034;
        tick();
        checks++; if (dec_class !== 4'd5 || dec_imm !== 32'h00000800 || dec_rd !== 5'd1 || dec_rd_wen !== 1'b1)
            begin errors++; $display("FAIL jal got cls %0d imm %h rd %0d wen %0b exp 5 800 1 1", dec_class, dec_imm, dec_rd, dec_rd_wen); end
        instruction_pld = 32'h123453B7; instruction_pc = 32'h80000038;
        tick();
        instruction_vld = 1'b0;
        checks++; if (dec_class !== 4'd7 || dec_imm !== 32'h12345000 || dec_rd !== 5'd7)
            begin errors++; $display("FAIL lui got cls %0d imm %h rd %0d exp 7 12345000 7", dec_class, dec_imm, dec_rd); end
        checks++; if (dut.u_sb.busy_q !== 32'h00000082) begin errors++; $display("FAIL imm_busy got %h exp 00000082", dut.u_sb.busy_q); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_i();
        test_raw_hazard();
        test_backpressure();
        test_flush();
        test_illegal_x0();
        test_imm_formats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
